// File: rtl/cnn_layer_2_bias_relu_pool_pkg.sv
// Layer-2 shared constants for the bias/ReLU/requant/pool stage.
// Derived widths are computed from the base constants.
package cnn_layer_2_bias_relu_pool_pkg;

  localparam int L2_ACI_BW = 22;
  localparam int L2_B_BW   = 16;
  localparam int L2_O_F_BW = 8;
  localparam int L2_SHIFT  = 6;
  localparam int L2_IN_W   = 12;
  localparam int L2_IN_H   = 12;
  localparam int L2_COL_BW = $clog2(L2_IN_W);
  localparam int L2_ROW_BW = $clog2(L2_IN_H);

  // Row-buffer address width. A 2-pixel-wide map still needs a 1-bit address.
  function automatic int addr_bw(input int in_w);
    return (in_w > 2) ? $clog2(in_w / 2) : 1;
  endfunction

endpackage

// File: rtl/cnn_layer_2_bias_relu_pool_row_buffer.sv
// One-row store of horizontal pool maxima from even rows.
// Synchronous write, combinational read, storage is not reset.
module pool_row_buffer #(
  parameter int DEPTH   = 6,
  parameter int DATA_BW = 8,
  parameter int ADDR_BW = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [DATA_BW-1:0] wdata,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [DATA_BW-1:0] rdata
);

  logic [DATA_BW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cnn_layer_2_bias_relu_pool.sv
// CNN layer-2 post-accumulation: bias add, ReLU, shift requantization with
// unsigned saturation, then 2x2/stride-2 max pooling over raster input.
module cnn_layer_2_bias_relu_pool
  import cnn_layer_2_bias_relu_pool_pkg::*;
#(
  parameter int ACI_BW = L2_ACI_BW,
  parameter int B_BW   = L2_B_BW,
  parameter int O_F_BW = L2_O_F_BW,
  parameter int SHIFT  = L2_SHIFT,
  parameter int IN_W   = L2_IN_W,
  parameter int IN_H   = L2_IN_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic [B_BW-1:0]   bias,
  input  logic              in_valid,
  input  logic [ACI_BW-1:0] in_sum,
  output logic              out_valid,
  output logic [O_F_BW-1:0] out_data,
  output logic              frame_done
);

  localparam int COL_BW  = $clog2(IN_W);
  localparam int ROW_BW  = $clog2(IN_H);
  localparam int ADDR_BW = addr_bw(IN_W);
  localparam int SUM_BW  = ACI_BW + 1;

  logic [SUM_BW-1:0]  s;
  logic [SUM_BW-1:0]  sh;
  logic [O_F_BW-1:0]  q_next;
  logic [O_F_BW-1:0]  q_r;
  logic               s1_valid;

  logic [COL_BW-1:0]  col;
  logic [ROW_BW-1:0]  row;
  logic [O_F_BW-1:0]  pair_reg;
  logic [O_F_BW-1:0]  hmax_next;
  logic [O_F_BW-1:0]  hmax_r;
  logic               h_valid;
  logic               h_even_row;
  logic               h_last;
  logic [ADDR_BW-1:0] h_addr;
  logic [O_F_BW-1:0]  buf_rdata;
  logic [O_F_BW-1:0]  vmax;
  logic               buf_we;
  logic               emit;

  // Negative sums take the ReLU path, so a logical shift of s suffices.
  always_comb begin
    s  = {in_sum[ACI_BW-1], in_sum} + {{(SUM_BW-B_BW){bias[B_BW-1]}}, bias};
    sh = s >> SHIFT;
    if (s[SUM_BW-1])              q_next = '0;
    else if (|sh[SUM_BW-1:O_F_BW]) q_next = '1;
    else                           q_next = sh[O_F_BW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r      <= '0;
      s1_valid <= 1'b0;
    end else if (soft_rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) q_r <= q_next;
    end
  end

  assign hmax_next = (q_r > pair_reg) ? q_r : pair_reg;

  // Horizontal max is registered so the vertical stage lands two edges after the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      pair_reg   <= '0;
      hmax_r     <= '0;
      h_valid    <= 1'b0;
      h_even_row <= 1'b0;
      h_last     <= 1'b0;
      h_addr     <= '0;
    end else if (soft_rst) begin
      col      <= '0;
      row      <= '0;
      pair_reg <= '0;
      h_valid  <= 1'b0;
    end else begin
      h_valid <= 1'b0;
      if (s1_valid) begin
        if (!col[0]) begin
          pair_reg <= q_r;
        end else begin
          hmax_r     <= hmax_next;
          h_valid    <= 1'b1;
          h_even_row <= !row[0];
          h_addr     <= ADDR_BW'(col >> 1);
          h_last     <= (row == ROW_BW'(IN_H - 1)) && (col == COL_BW'(IN_W - 1));
        end
        if (col == COL_BW'(IN_W - 1)) begin
          col <= '0;
          row <= (row == ROW_BW'(IN_H - 1)) ? '0 : row + ROW_BW'(1);
        end else begin
          col <= col + COL_BW'(1);
        end
      end
    end
  end

  assign buf_we = h_valid && h_even_row && !soft_rst;
  assign emit   = h_valid && !h_even_row;
  assign vmax   = (buf_rdata > hmax_r) ? buf_rdata : hmax_r;

  pool_row_buffer #(
    .DEPTH   (IN_W / 2),
    .DATA_BW (O_F_BW),
    .ADDR_BW (ADDR_BW)
  ) u_row_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (h_addr),
    .wdata (hmax_r),
    .raddr (h_addr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else if (soft_rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && h_last;
      if (emit) out_data <= vmax;
    end
  end

endmodule

// File: tb/tb_cnn_layer_2_bias_relu_pool.sv
// Randomized self-checking bench: frame-array reference model of bias/ReLU/
// requant/2x2 max-pool, checked on every output pulse including latency.
module tb_cnn_layer_2_bias_relu_pool;

  localparam int W     = 12;
  localparam int H     = 12;
  localparam int SHIFT = 6;
  localparam int OMAX  = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        soft_rst;
  logic [15:0] bias;
  logic        in_valid;
  logic [21:0] in_sum;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        frame_done;

  cnn_layer_2_bias_relu_pool #(
    .ACI_BW (22),
    .B_BW   (16),
    .O_F_BW (8),
    .SHIFT  (SHIFT),
    .IN_W   (W),
    .IN_H   (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_rst   (soft_rst),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int val;
    int cyc;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   pix[H][W];
  int   mr = 0;
  int   mc = 0;
  int   bias_i = 0;
  int   hold = 0;

  function automatic int quant(input int sum, input int b);
    longint t;
    t = longint'(sum) + longint'(b);
    if (t < 0) return 0;
    t = t / (64'sd1 <<< SHIFT);
    return (t > OMAX) ? OMAX : int'(t);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_push(input int v, input int ec);
    exp_t e;
    pix[mr][mc] = quant(v, bias_i);
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      e.val  = max2(max2(pix[mr-1][mc-1], pix[mr-1][mc]), max2(pix[mr][mc-1], pix[mr][mc]));
      e.cyc  = ec;
      e.last = (mr == H - 1) && (mc == W - 1);
      expq.push_back(e);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endfunction

  function automatic void drop_from(input int c);
    exp_t keep[$];
    foreach (expq[i]) if (expq[i].cyc < c) keep.push_back(expq[i]);
    expq = keep;
    mr = 0;
    mc = 0;
  endfunction

  // Output monitor: every pulse is matched in order against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
    end else if (out_valid) begin
      if (expq.size() == 0) begin
        check("spurious_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("out_data", out_data, e.val);
        check("latency", cyc, e.cyc);
        check("frame_done", frame_done, e.last);
        hold = e.val;
      end
    end else begin
      check("out_hold", out_data, hold);
      check("done_no_valid", frame_done, 0);
    end
  end

  function automatic int pixel_value(input int mode, input int r, input int c);
    int v;
    v = int'($urandom_range(0, 40000)) - 10000;
    if (mode == 1) begin
      v = (r * W + c) * 250 - 3000;
    end else if (mode == 2) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 4194303)) - 2097152;
    end else if (r < 2 && c < 10) begin
      case (c / 2)
        0: v = 64 * (r * 2 + (c % 2) + 1);
        1: v = -1000;
        2: v = 100;
        3: v = (r == 1 && c == 7) ? -5 : (1 << 20);
        default: v = (r == 1 && c == 9) ? (1 << 20) : -50;
      endcase
    end
    return v;
  endfunction

  task automatic send_pixel(input int v, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sum   = v[21:0];
    model_push(v, cyc + 3);
  endtask

  task automatic run_frame(input int mode, input int max_gap, input int npix);
    for (int p = 0; p < npix; p++) begin
      send_pixel(pixel_value(mode, mr, mc), int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic set_bias(input int b);
    bias_i = b;
    bias   = b[15:0];
  endtask

  task automatic do_soft_rst;
    @(posedge clk); #1;
    soft_rst = 1'b1;
    in_valid = 1'b1;
    in_sum   = 22'($urandom);
    drop_from(cyc + 1);
    @(posedge clk); #1;
    soft_rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("soft_rst_quiet", out_valid, 0);
    end
  endtask

  task automatic do_hard_rst;
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    drop_from(cyc);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_quiet", out_valid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d outputs pending", expq.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    soft_rst = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    set_bias(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_frame_done", frame_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(0, 0, W * H);
    idle(4);
    set_bias(-36);
    run_frame(0, 0, W * H);
    idle(4);
    set_bias(999);
    run_frame(0, 0, W * H);
    idle(4);

    set_bias(int'($urandom_range(0, 4000)) - 2000);
    run_frame(1, 0, W * H);
    run_frame(1, 0, W * H);
    run_frame(1, 5, W * H);
    idle(4);
    set_bias(int'($urandom_range(0, 65535)) - 32768);
    run_frame(2, 3, W * H);
    idle(4);

    set_bias(int'($urandom_range(0, 4000)) - 2000);
    run_frame(1, 0, 5 * W + 3);
    do_soft_rst();
    run_frame(2, 0, W * H);
    idle(4);

    run_frame(2, 2, 5 * W + 7);
    do_hard_rst();
    run_frame(1, 0, W * H);
    idle(8);

    check("pending_outputs", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
